branch_predict_unit: RTL and testbench

//  Next-generation PC/branch unit: owns the fetch PC register, predicts the next PC via a

---
 rtl/riscv_branch_pkg.sv | 39 +++
 rtl/btb_table.sv | 55 +++++
 rtl/branch_predict_unit.sv | 137 +++++++++++++
 tb/tb_branch_predict_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_branch_pkg.sv
// Shared encodings and BTB entry layout for the branch predict unit.
package riscv_branch_pkg;

   // Branch condition encodings (funct3)
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // 2-bit saturating counter states; bit 1 set means predict taken
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Tag/target fields are stored at this width; the unit supports XLEN up to 32
   localparam int unsigned BTB_XLEN = 32;

   typedef struct packed {
      logic                valid;
      logic [BTB_XLEN-1:0] tag;
      logic [BTB_XLEN-1:0] target;
      logic [1:0]          ctr;
   } btb_entry_t;

   // Saturating counter step toward the resolved direction
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (ctr == ST) ? ST : ctr + 2'd1;
      end else begin
         res = (ctr == SNT) ? SNT : ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and EX
// update lookup) and one synchronous write port. Only valid bits are reset.
module btb_table
   import riscv_branch_pkg::*;
#(
   parameter int unsigned BTB_ENTRIES = 16,
   localparam int unsigned IDX = $clog2(BTB_ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX-1:0]   fetch_idx,
   output btb_entry_t       fetch_entry,
   input  logic [IDX-1:0]   ex_idx,
   output btb_entry_t       ex_entry,
   input  logic             we,
   input  logic [IDX-1:0]   wr_idx,
   input  btb_entry_t       wr_entry
);

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [BTB_XLEN-1:0]    tag_q    [BTB_ENTRIES];
   logic [BTB_XLEN-1:0]    target_q [BTB_ENTRIES];
   logic [1:0]             ctr_q    [BTB_ENTRIES];

   // Valid bits: cleared on reset, set by any write
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_idx] <= wr_entry.valid;
      end
   end

   // Payload fields: unreset, written alongside the valid bit
   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_idx]    <= wr_entry.tag;
         target_q[wr_idx] <= wr_entry.target;
         ctr_q[wr_idx]    <= wr_entry.ctr;
      end
   end

   // Read ports see pre-write contents (read-before-write)
   always_comb begin
      fetch_entry.valid  = valid_q[fetch_idx];
      fetch_entry.tag    = tag_q[fetch_idx];
      fetch_entry.target = target_q[fetch_idx];
      fetch_entry.ctr    = ctr_q[fetch_idx];
      ex_entry.valid     = valid_q[ex_idx];
      ex_entry.tag       = tag_q[ex_idx];
      ex_entry.target    = target_q[ex_idx];
      ex_entry.ctr       = ctr_q[ex_idx];
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch PC owner: BTB-based next-PC prediction, EX branch resolution,
// mispredict/misalign redirect and BTB training.
module branch_predict_unit
   import riscv_branch_pkg::*;
#(
   parameter int unsigned    XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter logic [XLEN-1:0] TRAP_PC    = XLEN'(4),
   parameter int unsigned    BTB_ENTRIES = 16,
   localparam int unsigned   IDX         = $clog2(BTB_ENTRIES)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pred_next,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic            ex_jal,
   input  logic            ex_jalr,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_pred_next,
   output logic [XLEN-1:0] ex_link,
   output logic            flush,
   output logic            misalign
);

   logic [IDX-1:0]      fetch_idx, ex_idx;
   logic [BTB_XLEN-1:0] fetch_tag, ex_tag;
   btb_entry_t          fetch_entry, ex_entry, wr_entry;
   logic                fetch_hit, ex_hit, we;
   logic                cond_ok, cond_taken, taken, ctrl_op, mispredict;
   logic [XLEN-1:0]     jalr_sum, target, actual_next;

   assign fetch_idx = pc[IDX+1:2];
   assign ex_idx    = ex_pc[IDX+1:2];
   assign fetch_tag = BTB_XLEN'(pc >> (IDX + 2));
   assign ex_tag    = BTB_XLEN'(ex_pc >> (IDX + 2));

   btb_table #(
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .fetch_idx   (fetch_idx),
      .fetch_entry (fetch_entry),
      .ex_idx      (ex_idx),
      .ex_entry    (ex_entry),
      .we          (we),
      .wr_idx      (ex_idx),
      .wr_entry    (wr_entry)
   );

   // Fetch-side prediction: BTB hit with a taken-leaning counter, else sequential
   always_comb begin
      fetch_hit = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
      pred_next = (fetch_hit && fetch_entry.ctr[1]) ? fetch_entry.target[XLEN-1:0]
                                                    : pc + XLEN'(4);
   end

   // Branch condition evaluation; reserved funct3 codes resolve not-taken
   always_comb begin
      cond_ok    = 1'b1;
      cond_taken = 1'b0;
      case (ex_funct3)
         F3_BEQ:  cond_taken = (ex_rs1 == ex_rs2);
         F3_BNE:  cond_taken = (ex_rs1 != ex_rs2);
         F3_BLT:  cond_taken = ($signed(ex_rs1) < $signed(ex_rs2));
         F3_BGE:  cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
         F3_BLTU: cond_taken = (ex_rs1 < ex_rs2);
         F3_BGEU: cond_taken = (ex_rs1 >= ex_rs2);
         default: cond_ok    = 1'b0;
      endcase
   end

   // Target, resolved next PC and redirect decisions
   always_comb begin
      jalr_sum    = ex_rs1 + ex_imm;
      target      = ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
      ex_link     = ex_pc + XLEN'(4);
      ctrl_op     = ex_branch | ex_jal | ex_jalr;
      taken       = ex_jal | ex_jalr | (ex_branch & cond_ok & cond_taken);
      actual_next = taken ? target : ex_link;
      misalign    = !rst && ex_valid && taken && (target[1:0] != 2'b00);
      mispredict  = !rst && ex_valid && ctrl_op && (actual_next != ex_pred_next);
      flush       = misalign | mispredict;
   end

   // BTB training: jumps always (re)allocate strong-taken; branches train on hit,
   // allocate weak-taken only when taken on a miss
   always_comb begin
      we       = 1'b0;
      wr_entry = ex_entry;
      ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);
      if (!rst && ex_valid && !misalign) begin
         if (ex_jal || ex_jalr) begin
            we              = 1'b1;
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = ex_tag;
            wr_entry.target = BTB_XLEN'(target);
            wr_entry.ctr    = ST;
         end else if (ex_branch && cond_ok) begin
            if (ex_hit) begin
               we           = 1'b1;
               wr_entry.ctr = ctr_next(ex_entry.ctr, taken);
               if (taken) begin
                  wr_entry.target = BTB_XLEN'(target);
               end
            end else if (taken) begin
               we              = 1'b1;
               wr_entry.valid  = 1'b1;
               wr_entry.tag    = ex_tag;
               wr_entry.target = BTB_XLEN'(target);
               wr_entry.ctr    = WT;
            end
         end
      end
   end

   // Fetch PC register: reset > trap > mispredict > stall > prediction
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (misalign) begin
         pc <= TRAP_PC;
      end else if (mispredict) begin
         pc <= actual_next;
      end else if (!stall) begin
         pc <= pred_next;
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: hand sequences for reset, training and
// redirect corner cases, then a table of EX resolution vectors.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst, stall;
   logic [31:0] pc, pred_next, ex_link;
   logic        ex_valid, ex_branch, ex_jal, ex_jalr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_next;
   logic        flush, misalign;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   branch_predict_unit #(
      .XLEN        (32),
      .RESET_PC    (32'h100),
      .TRAP_PC     (32'h4),
      .BTB_ENTRIES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .pc           (pc),
      .pred_next    (pred_next),
      .ex_valid     (ex_valid),
      .ex_branch    (ex_branch),
      .ex_jal       (ex_jal),
      .ex_jalr      (ex_jalr),
      .ex_funct3    (ex_funct3),
      .ex_pc        (ex_pc),
      .ex_imm       (ex_imm),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_pred_next (ex_pred_next),
      .ex_link      (ex_link),
      .flush        (flush),
      .misalign     (misalign)
   );

   typedef struct packed {
      logic        valid;
      logic        br;
      logic        jal;
      logic        jalr;
      logic [2:0]  f3;
      logic [31:0] epc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] pred;
      logic        exp_flush;
      logic        exp_mis;
      logic [31:0] exp_next;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                        input logic [31:0] p, input logic [31:0] imm, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] pred);
      @(negedge clk);
      ex_valid = 1'b1; ex_branch = br; ex_jal = jal; ex_jalr = jalr; ex_funct3 = f3;
      ex_pc = p; ex_imm = imm; ex_rs1 = r1; ex_rs2 = r2; ex_pred_next = pred;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
   endtask

   // Move pc to addr via a reserved-funct3 branch: not taken, never trains the BTB
   task automatic redirect(input logic [31:0] addr);
      drive(1'b1, 1'b0, 1'b0, 3'b010, addr - 32'd4, 32'h0, 32'h0, 32'h0, addr ^ 32'h100);
      tick();
      chk("redirect_pc", pc, addr);
   endtask

   function automatic vec_t mk(input logic v, input logic br, input logic jal, input logic jalr,
                               input logic [2:0] f3, input logic [31:0] p, input logic [31:0] imm,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] pred, input logic ef, input logic em,
                               input logic [31:0] en);
      vec_t t;
      t = '{v, br, jal, jalr, f3, p, imm, r1, r2, pred, ef, em, en};
      return t;
   endfunction

   initial begin
      logic [31:0] exp_pc;

      // ex_pc=0x300, imm=0x40: taken -> 0x340, not taken -> 0x304
      vecs[0]  = mk(1, 1, 0, 0, 3'b000, 32'h300, 32'h40, 32'd7, 32'd7, 32'h304, 1, 0, 32'h340);
      vecs[1]  = mk(1, 1, 0, 0, 3'b000, 32'h300, 32'h40, 32'd7, 32'd8, 32'h304, 0, 0, 32'h0);
      vecs[2]  = mk(1, 1, 0, 0, 3'b001, 32'h300, 32'h40, 32'd7, 32'd8, 32'h340, 0, 0, 32'h0);
      vecs[3]  = mk(1, 1, 0, 0, 3'b001, 32'h300, 32'h40, 32'd7, 32'd7, 32'h340, 1, 0, 32'h304);
      vecs[4]  = mk(1, 1, 0, 0, 3'b100, 32'h300, 32'h40, 32'hFFFFFFFB, 32'd3, 32'h304,
                    1, 0, 32'h340);
      vecs[5]  = mk(1, 1, 0, 0, 3'b101, 32'h300, 32'h40, 32'hFFFFFFFB, 32'd3, 32'h304,
                    0, 0, 32'h0);
      vecs[6]  = mk(1, 1, 0, 0, 3'b101, 32'h300, 32'h40, 32'd3, 32'd3, 32'h304, 1, 0, 32'h340);
      vecs[7]  = mk(1, 1, 0, 0, 3'b110, 32'h300, 32'h40, 32'd3, 32'hFFFFFFFB, 32'h304,
                    1, 0, 32'h340);
      vecs[8]  = mk(1, 1, 0, 0, 3'b111, 32'h300, 32'h40, 32'hFFFFFFFB, 32'd3, 32'h340,
                    0, 0, 32'h0);
      vecs[9]  = mk(1, 1, 0, 0, 3'b010, 32'h300, 32'h40, 32'd7, 32'd7, 32'h304, 0, 0, 32'h0);
      vecs[10] = mk(1, 1, 0, 0, 3'b011, 32'h300, 32'h40, 32'd7, 32'd8, 32'h340, 1, 0, 32'h304);
      vecs[11] = mk(1, 0, 1, 0, 3'b000, 32'h300, 32'hFFFFFF00, 32'h0, 32'h0, 32'h304,
                    1, 0, 32'h200);
      vecs[12] = mk(1, 0, 0, 1, 3'b000, 32'h300, 32'h10, 32'h123, 32'h0, 32'h304, 1, 1, 32'h4);
      vecs[13] = mk(1, 0, 0, 1, 3'b000, 32'h300, 32'h3, 32'h1001, 32'h0, 32'h1004, 0, 0, 32'h0);
      vecs[14] = mk(1, 0, 1, 0, 3'b000, 32'hFFFFFFF0, 32'h20, 32'h0, 32'h0, 32'hFFFFFFF4,
                    1, 0, 32'h10);
      vecs[15] = mk(1, 1, 0, 0, 3'b000, 32'h300, 32'h2, 32'd1, 32'd1, 32'h304, 1, 1, 32'h4);
      vecs[16] = mk(1, 1, 0, 0, 3'b001, 32'h300, 32'h2, 32'd1, 32'd1, 32'h304, 0, 0, 32'h0);
      vecs[17] = mk(1, 0, 0, 0, 3'b000, 32'h300, 32'h40, 32'd1, 32'd1, 32'hDEAD, 0, 0, 32'h0);
      vecs[18] = mk(0, 0, 1, 0, 3'b000, 32'h300, 32'h40, 32'd0, 32'd0, 32'h304, 0, 0, 32'h0);
      vecs[19] = mk(1, 1, 0, 0, 3'b110, 32'h300, 32'h40, 32'hFFFFFFFB, 32'd3, 32'h340,
                    1, 0, 32'h304);

      // Reset with a misaligned JAL presented: outputs must stay quiet
      rst = 1'b1; stall = 1'b0;
      ex_valid = 1'b1; ex_branch = 1'b0; ex_jal = 1'b1; ex_jalr = 1'b0; ex_funct3 = 3'b000;
      ex_pc = 32'h500; ex_imm = 32'h2; ex_rs1 = 32'h0; ex_rs2 = 32'h0; ex_pred_next = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pc", pc, 32'h100);
      chk("reset_flush", {31'b0, flush}, 32'h0);
      chk("reset_misalign", {31'b0, misalign}, 32'h0);
      @(negedge clk);
      rst = 1'b0; ex_valid = 1'b0; ex_jal = 1'b0;
      @(posedge clk); #1;
      chk("fetch_seq1", pc, 32'h104);
      @(posedge clk); #1;
      chk("fetch_seq2", pc, 32'h108);
      @(negedge clk);
      stall = 1'b1;
      @(posedge clk); #1;
      chk("stall_hold", pc, 32'h108);

      // BEQ taken, predicted sequential: flush, redirect, allocate WT
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h10, 32'h20, 32'd5, 32'd5, 32'h14);
      chk("beq_flush", {31'b0, flush}, 32'h1);
      chk("beq_misalign", {31'b0, misalign}, 32'h0);
      tick();
      chk("beq_pc", pc, 32'h30);
      chk("beq_ctr", {30'b0, dut.u_btb.ctr_q[4]}, 32'h2);
      redirect(32'h10);
      chk("beq_predict", pred_next, 32'h30);
      redirect(32'h50);
      chk("tag_miss_predict", pred_next, 32'h54);

      // Signed vs unsigned less-than on the same operands
      drive(1'b1, 1'b0, 1'b0, 3'b100, 32'h40, 32'h10, 32'hFFFFFFFF, 32'd1, 32'h44);
      chk("blt_flush", {31'b0, flush}, 32'h1);
      tick();
      chk("blt_pc", pc, 32'h50);
      chk("blt_ctr", {30'b0, dut.u_btb.ctr_q[0]}, 32'h2);
      drive(1'b1, 1'b0, 1'b0, 3'b110, 32'h40, 32'h10, 32'hFFFFFFFF, 32'd1, 32'h50);
      chk("bltu_flush", {31'b0, flush}, 32'h1);
      tick();
      chk("bltu_pc", pc, 32'h44);
      chk("bltu_ctr", {30'b0, dut.u_btb.ctr_q[0]}, 32'h1);
      redirect(32'h40);
      chk("bltu_predict", pred_next, 32'h44);

      // JALR clears bit 0 of the target; link is ex_pc+4
      drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h84, 32'h0, 32'h1001, 32'h0, 32'h88);
      chk("jalr_link", ex_link, 32'h88);
      chk("jalr_flush", {31'b0, flush}, 32'h1);
      tick();
      chk("jalr_pc", pc, 32'h1000);
      chk("jalr_ctr", {30'b0, dut.u_btb.ctr_q[1]}, 32'h3);
      redirect(32'h84);
      chk("jalr_predict", pred_next, 32'h1000);
      stall = 1'b0;
      @(posedge clk); #1;
      chk("jalr_fetch_follow", pc, 32'h1000);
      stall = 1'b1;

      // Counter training: taken, taken, not-taken -> 10, 11, 10
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'h40, 32'd1, 32'd1, 32'h24);
      tick();
      chk("train1_pc", pc, 32'h60);
      chk("train1_ctr", {30'b0, dut.u_btb.ctr_q[8]}, 32'h2);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'h40, 32'd1, 32'd1, 32'h60);
      chk("train2_noflush", {31'b0, flush}, 32'h0);
      tick();
      chk("train2_pc", pc, 32'h60);
      chk("train2_ctr", {30'b0, dut.u_btb.ctr_q[8]}, 32'h3);
      drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'h40, 32'd1, 32'd2, 32'h60);
      chk("train3_flush", {31'b0, flush}, 32'h1);
      tick();
      chk("train3_pc", pc, 32'h24);
      chk("train3_ctr", {30'b0, dut.u_btb.ctr_q[8]}, 32'h2);
      redirect(32'h20);
      chk("train_predict", pred_next, 32'h60);

      // Redirect beats stall; misaligned JAL traps without touching the BTB
      drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h100, 32'h0, 32'h0, 32'h104);
      tick();
      chk("stall_redirect_pc", pc, 32'h200);
      drive(1'b0, 1'b1, 1'b0, 3'b000, 32'h208, 32'h2, 32'h0, 32'h0, 32'h20C);
      chk("jal_misalign", {31'b0, misalign}, 32'h1);
      chk("jal_mis_flush", {31'b0, flush}, 32'h1);
      tick();
      chk("trap_pc", pc, 32'h4);
      chk("trap_no_alloc", {31'b0, dut.u_btb.valid_q[2]}, 32'h0);

      // Resolution vectors with fetch stalled: pc moves only on redirect
      exp_pc = 32'h4;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].f3, vecs[i].epc, vecs[i].imm,
               vecs[i].rs1, vecs[i].rs2, vecs[i].pred);
         ex_valid = vecs[i].valid;
         #1;
         chk($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
         chk($sformatf("vec%0d_misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
         chk($sformatf("vec%0d_link", i), ex_link, vecs[i].epc + 32'd4);
         tick();
         if (vecs[i].exp_flush) exp_pc = vecs[i].exp_next;
         chk($sformatf("vec%0d_pc", i), pc, exp_pc);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
